// File: rtl/run_detect_mealy.sv
// Run detector: flags a run of RUN_LEN identical valid bits with a Mealy output,
// tracks the current run length and keeps a saturating count of detect cycles.
module run_detect_mealy #(
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned HIT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic [1:0]       mode,
    input  logic             hit_clr,
    output logic             y,
    output logic             y_pol,
    output logic [7:0]       run_len,
    output logic [HIT_W-1:0] hit_cnt
);

    // run_len saturates at RUN_LEN; a match with run_len >= RUN_LEN-1 completes a run
    localparam logic [7:0]       RunMax = 8'(RUN_LEN);
    localparam logic [7:0]       RunThr = 8'(RUN_LEN - 1);
    localparam logic [7:0]       RunOne = 8'd1;
    localparam logic [HIT_W-1:0] HitMax = {HIT_W{1'b1}};
    localparam logic [HIT_W-1:0] HitOne = HIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_ZERO = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       run_len_q, run_len_d;
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;

    logic same_bit;
    logic pol_en;
    logic run_long;
    logic run_inc_sat;

    // Detect condition: valid bit continuing the current run, long enough, polarity enabled
    always_comb begin
        same_bit = ((state_q == S_ONE) && x) || ((state_q == S_ZERO) && !x);
        // mode[0] enables runs of ones, mode[1] enables runs of zeros
        pol_en   = x ? mode[0] : mode[1];
        run_long = (run_len_q >= RunThr);
        // Reset masks the flag so nothing leaks out while the state is being cleared
        y        = !rst && x_valid && same_bit && run_long && pol_en;
        y_pol    = y && x;
    end

    // Next-state and run length; tracking is independent of mode
    always_comb begin
        state_d     = state_q;
        run_len_d   = run_len_q;
        run_inc_sat = (run_len_q >= RunMax);
        if (x_valid) begin
            case (state_q)
                S_IDLE: begin
                    state_d   = x ? S_ONE : S_ZERO;
                    run_len_d = RunOne;
                end
                S_ONE: begin
                    if (x) begin
                        run_len_d = run_inc_sat ? RunMax : run_len_q + RunOne;
                    end else begin
                        state_d   = S_ZERO;
                        run_len_d = RunOne;
                    end
                end
                S_ZERO: begin
                    if (!x) begin
                        run_len_d = run_inc_sat ? RunMax : run_len_q + RunOne;
                    end else begin
                        state_d   = S_ONE;
                        run_len_d = RunOne;
                    end
                end
                default: begin
                    // Unused encoding: restart as if from idle
                    state_d   = x ? S_ONE : S_ZERO;
                    run_len_d = RunOne;
                end
            endcase
        end
    end

    // Saturating detect counter; clear wins over a simultaneous increment
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (hit_clr) begin
            hit_cnt_d = '0;
        end else if (y && (hit_cnt_q != HitMax)) begin
            hit_cnt_d = hit_cnt_q + HitOne;
        end
    end

    // State registers with synchronous reset overriding all other inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            run_len_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign run_len = run_len_q;
    assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_run_detect_mealy.sv
// Bench for run_detect_mealy: directed scenarios plus a randomized stream against a
// reference model. Expected values go into a scoreboard queue as stimulus is driven.
module tb_run_detect_mealy;

    typedef struct packed {
        logic       y;
        logic       yp;
        logic [7:0] rl;
        logic [7:0] hc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       x;
    logic       x_valid;
    logic [1:0] mode;
    logic       hit_clr;

    logic       ya, ypa;
    logic [7:0] rla;
    logic [7:0] hca;
    logic       yb, ypb;
    logic [7:0] rlb;
    logic [1:0] hcb;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    run_detect_mealy #(.RUN_LEN(3), .HIT_W(8)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .x_valid (x_valid),
        .mode    (mode),
        .hit_clr (hit_clr),
        .y       (ya),
        .y_pol   (ypa),
        .run_len (rla),
        .hit_cnt (hca)
    );

    run_detect_mealy #(.RUN_LEN(2), .HIT_W(2)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .x_valid (x_valid),
        .mode    (mode),
        .hit_clr (hit_clr),
        .y       (yb),
        .y_pol   (ypb),
        .run_len (rlb),
        .hit_cnt (hcb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end at 1 time unit after a rising edge
    task automatic do_reset();
        rst = 1'b1; x_valid = 1'b0; x = 1'b0; hit_clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic oy, op, oyb, opb;
        rst = 1'b1; x_valid = 1'b1; x = 1'b1; mode = 2'b11; hit_clr = 1'b0;
        @(negedge clk); oy = ya; op = ypa; oyb = yb; opb = ypb;
        @(posedge clk); #1;
        n_chk++; if (oy !== 1'b0) begin n_fail++; $display("FAIL reset_y got %b exp 0", oy); end
        n_chk++; if (op !== 1'b0) begin n_fail++; $display("FAIL reset_ypol got %b exp 0", op); end
        n_chk++; if (oyb !== 1'b0) begin n_fail++; $display("FAIL reset_y_b got %b exp 0", oyb); end
        n_chk++; if (opb !== 1'b0) begin n_fail++; $display("FAIL reset_ypol_b got %b exp 0", opb); end
        n_chk++; if (rla !== 8'd0) begin n_fail++; $display("FAIL reset_runlen got %0d exp 0", rla); end
        n_chk++; if (hca !== 8'd0) begin n_fail++; $display("FAIL reset_hitcnt got %0d exp 0", hca); end
        n_chk++; if (rlb !== 8'd0) begin n_fail++; $display("FAIL reset_runlen_b got %0d exp 0", rlb); end
        n_chk++; if (hcb !== 2'd0) begin n_fail++; $display("FAIL reset_hitcnt_b got %0d exp 0", hcb); end
        rst = 1'b0; x_valid = 1'b0;
    endtask

    task automatic test_basic_stream();
        int   xs[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int   ey[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        int   ep[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        int   er[8] = '{1, 2, 3, 3, 1, 2, 3, 3};
        int   eh[8] = '{0, 0, 1, 2, 2, 2, 3, 4};
        exp_t e;
        logic oy, op;
        do_reset(); mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{y: 1'(ey[i]), yp: 1'(ep[i]), rl: 8'(er[i]), hc: 8'(eh[i])});
            x_valid = 1'b1; x = 1'(xs[i]);
            @(negedge clk); oy = ya; op = ypa;
            @(posedge clk); #1;
            e = sb.pop_front();
            n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL basic_y[%0d] got %b exp %b", i, oy, e.y); end
            n_chk++; if (op !== e.yp) begin n_fail++; $display("FAIL basic_ypol[%0d] got %b exp %b", i, op, e.yp); end
            n_chk++; if (rla !== e.rl) begin n_fail++; $display("FAIL basic_runlen[%0d] got %0d exp %0d", i, rla, e.rl); end
            n_chk++; if (hca !== e.hc) begin n_fail++; $display("FAIL basic_hitcnt[%0d] got %0d exp %0d", i, hca, e.hc); end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_mode_gating();
        int   xs[6]    = '{0, 0, 0, 1, 1, 1};
        int   er[6]    = '{1, 2, 3, 1, 2, 3};
        int   ey0[6]   = '{0, 0, 0, 0, 0, 1};
        int   eh0[6]   = '{0, 0, 0, 0, 0, 1};
        int   ey1[6]   = '{0, 0, 1, 0, 0, 0};
        int   eh1[6]   = '{0, 0, 1, 1, 1, 1};
        exp_t e;
        logic oy, op, eyv;
        for (int p = 0; p < 2; p++) begin
            do_reset(); mode = (p == 0) ? 2'b01 : 2'b10;
            for (int i = 0; i < 6; i++) begin
                eyv = (p == 0) ? 1'(ey0[i]) : 1'(ey1[i]);
                sb.push_back('{y: eyv, yp: eyv & 1'(xs[i]), rl: 8'(er[i]),
                               hc: (p == 0) ? 8'(eh0[i]) : 8'(eh1[i])});
                x_valid = 1'b1; x = 1'(xs[i]);
                @(negedge clk); oy = ya; op = ypa;
                @(posedge clk); #1;
                e = sb.pop_front();
                n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL mode%0d_y[%0d] got %b exp %b", p, i, oy, e.y); end
                n_chk++; if (op !== e.yp) begin n_fail++; $display("FAIL mode%0d_ypol[%0d] got %b exp %b", p, i, op, e.yp); end
                n_chk++; if (rla !== e.rl) begin n_fail++; $display("FAIL mode%0d_runlen[%0d] got %0d exp %0d", p, i, rla, e.rl); end
                n_chk++; if (hca !== e.hc) begin n_fail++; $display("FAIL mode%0d_hitcnt[%0d] got %0d exp %0d", p, i, hca, e.hc); end
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_valid_gap();
        int   xs[8] = '{1, 1, 0, 0, 0, 0, 0, 1};
        int   vs[8] = '{1, 1, 0, 0, 0, 0, 0, 1};
        int   ey[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        int   er[8] = '{1, 2, 2, 2, 2, 2, 2, 3};
        int   eh[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        exp_t e;
        logic oy, op;
        do_reset(); mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{y: 1'(ey[i]), yp: 1'(ey[i]), rl: 8'(er[i]), hc: 8'(eh[i])});
            x_valid = 1'(vs[i]); x = 1'(xs[i]);
            @(negedge clk); oy = ya; op = ypa;
            @(posedge clk); #1;
            e = sb.pop_front();
            n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL gap_y[%0d] got %b exp %b", i, oy, e.y); end
            n_chk++; if (op !== e.yp) begin n_fail++; $display("FAIL gap_ypol[%0d] got %b exp %b", i, op, e.yp); end
            n_chk++; if (rla !== e.rl) begin n_fail++; $display("FAIL gap_runlen[%0d] got %0d exp %0d", i, rla, e.rl); end
            n_chk++; if (hca !== e.hc) begin n_fail++; $display("FAIL gap_hitcnt[%0d] got %0d exp %0d", i, hca, e.hc); end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_alternating();
        int   xs[6] = '{1, 1, 0, 1, 1, 0};
        int   er[6] = '{1, 2, 1, 1, 2, 1};
        exp_t e;
        logic oy;
        do_reset(); mode = 2'b11;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{y: 1'b0, yp: 1'b0, rl: 8'(er[i]), hc: 8'd0});
            x_valid = 1'b1; x = 1'(xs[i]);
            @(negedge clk); oy = ya;
            @(posedge clk); #1;
            e = sb.pop_front();
            n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL alt_y[%0d] got %b exp %b", i, oy, e.y); end
            n_chk++; if (rla !== e.rl) begin n_fail++; $display("FAIL alt_runlen[%0d] got %0d exp %0d", i, rla, e.rl); end
            n_chk++; if (hca !== e.hc) begin n_fail++; $display("FAIL alt_hitcnt[%0d] got %0d exp %0d", i, hca, e.hc); end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_mode_enable_midrun();
        int   ms[4] = '{0, 0, 0, 1};
        int   ey[4] = '{0, 0, 0, 1};
        int   er[4] = '{1, 2, 3, 3};
        exp_t e;
        logic oy, op;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{y: 1'(ey[i]), yp: 1'(ey[i]), rl: 8'(er[i]), hc: 8'(ey[i])});
            mode = 2'(ms[i]); x_valid = 1'b1; x = 1'b1;
            @(negedge clk); oy = ya; op = ypa;
            @(posedge clk); #1;
            e = sb.pop_front();
            n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL midrun_y[%0d] got %b exp %b", i, oy, e.y); end
            n_chk++; if (op !== e.yp) begin n_fail++; $display("FAIL midrun_ypol[%0d] got %b exp %b", i, op, e.yp); end
            n_chk++; if (rla !== e.rl) begin n_fail++; $display("FAIL midrun_runlen[%0d] got %0d exp %0d", i, rla, e.rl); end
            n_chk++; if (hca !== e.hc) begin n_fail++; $display("FAIL midrun_hitcnt[%0d] got %0d exp %0d", i, hca, e.hc); end
        end
        x_valid = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int   rs[4] = '{0, 0, 1, 0};
        int   er[4] = '{1, 2, 0, 1};
        exp_t e;
        logic oy, op;
        do_reset(); mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{y: 1'b0, yp: 1'b0, rl: 8'(er[i]), hc: 8'd0});
            rst = 1'(rs[i]); x_valid = 1'b1; x = 1'b1;
            @(negedge clk); oy = ya; op = ypa;
            @(posedge clk); #1;
            e = sb.pop_front();
            n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL rstmid_y[%0d] got %b exp %b", i, oy, e.y); end
            n_chk++; if (op !== e.yp) begin n_fail++; $display("FAIL rstmid_ypol[%0d] got %b exp %b", i, op, e.yp); end
            n_chk++; if (rla !== e.rl) begin n_fail++; $display("FAIL rstmid_runlen[%0d] got %0d exp %0d", i, rla, e.rl); end
            n_chk++; if (hca !== e.hc) begin n_fail++; $display("FAIL rstmid_hitcnt[%0d] got %0d exp %0d", i, hca, e.hc); end
        end
        rst = 1'b0; x_valid = 1'b0;
    endtask

    // Instance b: RUN_LEN=2, HIT_W=2
    task automatic test_hit_saturation();
        int   ey[8] = '{0, 1, 1, 1, 1, 1, 1, 1};
        int   er[8] = '{1, 2, 2, 2, 2, 2, 2, 2};
        int   eh[8] = '{0, 1, 2, 3, 3, 3, 3, 0};
        int   cl[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        exp_t e;
        logic oy, op;
        do_reset(); mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{y: 1'(ey[i]), yp: 1'(ey[i]), rl: 8'(er[i]), hc: 8'(eh[i])});
            x_valid = 1'b1; x = 1'b1; hit_clr = 1'(cl[i]);
            @(negedge clk); oy = yb; op = ypb;
            @(posedge clk); #1;
            e = sb.pop_front();
            n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL sat_y[%0d] got %b exp %b", i, oy, e.y); end
            n_chk++; if (op !== e.yp) begin n_fail++; $display("FAIL sat_ypol[%0d] got %b exp %b", i, op, e.yp); end
            n_chk++; if (rlb !== e.rl) begin n_fail++; $display("FAIL sat_runlen[%0d] got %0d exp %0d", i, rlb, e.rl); end
            n_chk++; if ({6'd0, hcb} !== e.hc) begin n_fail++; $display("FAIL sat_hitcnt[%0d] got %0d exp %0d", i, hcb, e.hc); end
        end
        x_valid = 1'b0; hit_clr = 1'b0;
    endtask

    // Instance b: y on the second bit of every run
    task automatic test_run_len2();
        int   xs[8] = '{0, 0, 1, 1, 0, 1, 1, 1};
        int   ey[8] = '{0, 1, 0, 1, 0, 0, 1, 1};
        int   ep[8] = '{0, 0, 0, 1, 0, 0, 1, 1};
        int   er[8] = '{1, 2, 1, 2, 1, 1, 2, 2};
        int   eh[8] = '{0, 1, 1, 2, 2, 2, 3, 3};
        exp_t e;
        logic oy, op;
        do_reset(); mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{y: 1'(ey[i]), yp: 1'(ep[i]), rl: 8'(er[i]), hc: 8'(eh[i])});
            x_valid = 1'b1; x = 1'(xs[i]);
            @(negedge clk); oy = yb; op = ypb;
            @(posedge clk); #1;
            e = sb.pop_front();
            n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL rl2_y[%0d] got %b exp %b", i, oy, e.y); end
            n_chk++; if (op !== e.yp) begin n_fail++; $display("FAIL rl2_ypol[%0d] got %b exp %b", i, op, e.yp); end
            n_chk++; if (rlb !== e.rl) begin n_fail++; $display("FAIL rl2_runlen[%0d] got %0d exp %0d", i, rlb, e.rl); end
            n_chk++; if ({6'd0, hcb} !== e.hc) begin n_fail++; $display("FAIL rl2_hitcnt[%0d] got %0d exp %0d", i, hcb, e.hc); end
        end
        x_valid = 1'b0;
    endtask

    // Random stream on instance a, checked against a behavioural run model
    task automatic test_random();
        int   m_last = -1;
        int   m_cnt  = 0;
        int   m_hits = 0;
        logic b      = 1'b0;
        logic v, ey, en;
        exp_t e;
        logic oy, op;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) b = ~b;
            mode    = 2'($urandom_range(0, 3));
            hit_clr = ($urandom_range(0, 15) == 0);
            en      = b ? mode[0] : mode[1];
            ey      = v && (m_last == int'(b)) && (m_cnt + 1 >= 3) && en;
            if (v) begin
                if (m_last == int'(b)) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
                else m_cnt = 1;
                m_last = int'(b);
            end
            if (hit_clr) m_hits = 0;
            else if (ey && m_hits < 255) m_hits++;
            sb.push_back('{y: ey, yp: ey & b, rl: 8'(m_cnt), hc: 8'(m_hits)});
            x_valid = v; x = b;
            @(negedge clk); oy = ya; op = ypa;
            @(posedge clk); #1;
            e = sb.pop_front();
            n_chk++; if (oy !== e.y) begin n_fail++; $display("FAIL rand_y[%0d] got %b exp %b", i, oy, e.y); end
            n_chk++; if (op !== e.yp) begin n_fail++; $display("FAIL rand_ypol[%0d] got %b exp %b", i, op, e.yp); end
            n_chk++; if (rla !== e.rl) begin n_fail++; $display("FAIL rand_runlen[%0d] got %0d exp %0d", i, rla, e.rl); end
            n_chk++; if (hca !== e.hc) begin n_fail++; $display("FAIL rand_hitcnt[%0d] got %0d exp %0d", i, hca, e.hc); end
        end
        x_valid = 1'b0; hit_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; x_valid = 1'b0; mode = 2'b00; hit_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_stream();
        test_reset();
        test_mode_gating();
        test_valid_gap();
        test_alternating();
        test_mode_enable_midrun();
        test_reset_midrun();
        test_hit_saturation();
        test_run_len2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
